fill_counter: RTL and testbench
===============================

FILL_COUNTER -- requirements
Module: fill_counter

Interface
REQ-001 Parameter DEPTH, default 4, meaning terminal fill count (>=2).
REQ-002 Parameter ALMOST, default DEPTH-1, meaning almost_full threshold (1..DEPTH).
REQ-003 Localparam W = $clog2(DEPTH+1), meaning count width.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 clr  input  1  synchronous clear of count, flags and errors.
REQ-007 inc  input  1  fill request (+1).
REQ-008 dec  input  1  drain request (-1).
REQ-009 load  input  1  load count from load_val.
REQ-010 load_val  input  W  value for load.
REQ-011 count  output  W  current occupancy, registered.
REQ-012 empty  output  1  count==0, registered.
REQ-013 full  output  1  count==DEPTH, registered.
REQ-014 almost_full  output  1  count>=ALMOST, registered.
REQ-015 fill_done  output  1  sticky; set on entry to FULL.
REQ-016 done_pulse  output  1  single-cycle pulse on each entry to FULL.
REQ-017 err  output  1  sticky overflow/underflow/bad-load flag.

Function
REQ-018 Update priority SHALL be rst > clr > load > inc/dec.
REQ-019 FSM states SHALL be S_EMPTY (count 0), S_PART (0<count<DEPTH), S_FULL (count DEPTH); state always consistent with count.
REQ-020 inc only: count+1 if count<DEPTH; at DEPTH count holds and err sets.
REQ-021 dec only: count-1 if count>0; at 0 count holds and err sets.
REQ-022 inc and dec together: count unchanged, no error, including at 0 and DEPTH.
REQ-023 load: count<=min(load_val,DEPTH); load_val>DEPTH sets err; inc/dec ignored that cycle.
REQ-024 empty, full, almost_full SHALL reflect count in the same cycle count updates (derived from next-count, registered).
REQ-025 done_pulse SHALL assert for exactly the cycle after the update that moves state from non-FULL to S_FULL (via inc or load); not re-asserted while remaining FULL.
REQ-026 fill_done SHALL set with done_pulse and hold until clr or rst, even if count later drains.
REQ-027 err SHALL hold until clr or rst; error cycles do not change count.
REQ-028 clr SHALL, in one cycle, give count=0, empty=1, full=0, almost_full=(ALMOST==0 never, so 0), fill_done=0, done_pulse=0, err=0, state S_EMPTY.
REQ-029 Latency: input sampled at edge N visible on outputs after edge N; no combinational input-to-output paths.
REQ-030 Arithmetic SHALL never wrap; count is always within 0..DEPTH.

Reset
REQ-031 On rst: count=0, state S_EMPTY, empty=1, full=0, almost_full=0, fill_done=0, done_pulse=0, err=0.
REQ-032 rst mid-fill SHALL discard all in-flight inc/dec/load of that cycle.
REQ-033 rst SHALL be sampled only on posedge clk (no asynchronous terms).

Structure
REQ-034 Shared package qq_cnt_pkg SHALL hold the fill_state_t enum (S_EMPTY, S_PART, S_FULL) and default DEPTH constant.
REQ-035 Single module, no sub-module; next-count logic and flag registers in one always_ff plus one always_comb.
REQ-036 Parameter legality (DEPTH>=2, 1<=ALMOST<=DEPTH) SHALL be checked by elaboration-time assertion.

Verification (DEPTH=4, ALMOST=3)
REQ-037 rst, then 4 inc cycles -> count 1,2,3,4; almost_full at 3; full and one-cycle done_pulse at 4; fill_done=1.
REQ-038 At full, inc 2 cycles -> count stays 4, err=1, no second done_pulse; then dec -> count 3, full=0, fill_done still 1.
REQ-039 From empty, dec -> count 0, err=1; inc+dec same cycle at 0 -> count 0, no further effect.
REQ-040 load load_val=7 -> count 4, err=1, done_pulse=1; load 2 with inc high -> count 2.
REQ-041 At count 3 assert clr with inc -> count 0, all flags/errors 0; rst asserted with load at count 2 -> reset values.

Source files
------------

// File: rtl/qq_cnt_pkg.sv
// Shared definitions for the fill counter family: occupancy states and default depth.
package qq_cnt_pkg;

  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } fill_state_t;

endpackage

// File: rtl/fill_counter.sv
// Saturating occupancy counter with registered empty/full/almost-full flags,
// a sticky fill-done flag, a one-cycle done pulse on entry to full, and a sticky error.
module fill_counter
  import qq_cnt_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ALMOST = DEPTH - 1,
  localparam int unsigned W     = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         empty,
  output logic         full,
  output logic         almost_full,
  output logic         fill_done,
  output logic         done_pulse,
  output logic         err
);

  if (DEPTH < 2 || ALMOST < 1 || ALMOST > DEPTH) begin : gen_bad_params
    $fatal(1, "fill_counter: illegal DEPTH/ALMOST combination");
  end

  localparam logic [W-1:0] DepthW  = W'(DEPTH);
  localparam logic [W-1:0] AlmostW = W'(ALMOST);

  fill_state_t  state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         empty_q, empty_d;
  logic         full_q, full_d;
  logic         almost_full_q, almost_full_d;
  logic         fill_done_q, fill_done_d;
  logic         done_pulse_q, done_pulse_d;
  logic         err_q, err_d;

  always_comb begin
    count_d      = count_q;
    err_d        = err_q;
    fill_done_d  = fill_done_q;
    done_pulse_d = 1'b0;

    if (clr) begin
      count_d     = '0;
      err_d       = 1'b0;
      fill_done_d = 1'b0;
    end else if (load) begin
      if (load_val > DepthW) begin
        count_d = DepthW;
        err_d   = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (inc && !dec) begin
      if (count_q == DepthW) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end else if (dec && !inc) begin
      if (count_q == '0) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q - W'(1);
      end
    end

    // State is a pure function of the next count, so it can never disagree with it.
    if (count_d == '0) begin
      state_d = S_EMPTY;
    end else if (count_d == DepthW) begin
      state_d = S_FULL;
    end else begin
      state_d = S_PART;
    end

    if (!clr && state_d == S_FULL && state_q != S_FULL) begin
      done_pulse_d = 1'b1;
      fill_done_d  = 1'b1;
    end

    empty_d       = (count_d == '0);
    full_d        = (count_d == DepthW);
    almost_full_d = (count_d >= AlmostW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_EMPTY;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      fill_done_q   <= 1'b0;
      done_pulse_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      fill_done_q   <= fill_done_d;
      done_pulse_q  <= done_pulse_d;
      err_q         <= err_d;
    end
  end

  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign fill_done   = fill_done_q;
  assign done_pulse  = done_pulse_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fill_counter.sv
// Scoreboard bench for fill_counter (DEPTH=4, ALMOST=3): a behavioural model pushes
// expected outputs as stimulus is applied; each test pops and compares after the edge.
module tb_fill_counter;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ALMOST = 3;
  localparam int unsigned W      = 3;

  typedef struct packed {
    logic [W-1:0] count;
    logic         empty;
    logic         full;
    logic         almost_full;
    logic         fill_done;
    logic         done_pulse;
    logic         err;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         inc = 1'b0;
  logic         dec = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         empty, full, almost_full, fill_done, done_pulse, err;

  int total = 0;
  int bad   = 0;

  obs_t sb[$];
  obs_t exp_o, obs_o;

  int   m_count = 0;
  logic m_fd    = 1'b0;
  logic m_err   = 1'b0;

  fill_counter #(
    .DEPTH  (DEPTH),
    .ALMOST (ALMOST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .inc         (inc),
    .dec         (dec),
    .load        (load),
    .load_val    (load_val),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .fill_done   (fill_done),
    .done_pulse  (done_pulse),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.count       = count;
    o.empty       = empty;
    o.full        = full;
    o.almost_full = almost_full;
    o.fill_done   = fill_done;
    o.done_pulse  = done_pulse;
    o.err         = err;
    return o;
  endfunction

  // Drives one cycle of stimulus, pushes the model's expectation, and waits past the edge.
  task automatic apply(input logic r, input logic c, input logic i, input logic d,
                       input logic l, input logic [W-1:0] v);
    obs_t e;
    int   old_count;
    logic dp;
    old_count = m_count;
    dp = 1'b0;
    if (r || c) begin
      m_count = 0;
      m_fd    = 1'b0;
      m_err   = 1'b0;
    end else begin
      if (l) begin
        if (int'(v) > DEPTH) begin
          m_count = DEPTH;
          m_err   = 1'b1;
        end else begin
          m_count = int'(v);
        end
      end else if (i && !d) begin
        if (m_count == DEPTH) m_err = 1'b1;
        else m_count = m_count + 1;
      end else if (d && !i) begin
        if (m_count == 0) m_err = 1'b1;
        else m_count = m_count - 1;
      end
      dp = (m_count == DEPTH) && (old_count != DEPTH);
      if (dp) m_fd = 1'b1;
    end
    e.count       = W'(m_count);
    e.empty       = (m_count == 0);
    e.full        = (m_count == DEPTH);
    e.almost_full = (m_count >= ALMOST);
    e.fill_done   = m_fd;
    e.done_pulse  = dp;
    e.err         = m_err;
    sb.push_back(e);
    rst = r; clr = c; inc = i; dec = d; load = l; load_val = v;
    @(posedge clk);
    #1;
    rst = 1'b0; clr = 1'b0; inc = 1'b0; dec = 1'b0; load = 1'b0; load_val = '0;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    exp_o = sb.pop_front();
    obs_o = sample();
    total++;
    if (obs_o !== exp_o) begin
      bad++;
      $display("FAIL reset_sb got=%h want=%h", obs_o, exp_o);
    end
    total++;
    if (obs_o !== obs_t'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0})) begin
      bad++;
      $display("FAIL reset_const got=%h", obs_o);
    end
  endtask

  task automatic test_fill();
    logic [W-1:0] want_cnt;
    for (int k = 1; k <= 4; k++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      exp_o = sb.pop_front();
      obs_o = sample();
      total++;
      if (obs_o !== exp_o) begin
        bad++;
        $display("FAIL fill_sb step=%0d got=%h want=%h", k, obs_o, exp_o);
      end
      want_cnt = W'(k);
      total++;
      if (count !== want_cnt || almost_full !== (k >= 3) || done_pulse !== (k == 4)) begin
        bad++;
        $display("FAIL fill_const step=%0d count=%0d af=%b dp=%b", k, count, almost_full,
                 done_pulse);
      end
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, (k < 2), (k == 2), 1'b0, '0);
      exp_o = sb.pop_front();
      obs_o = sample();
      total++;
      if (obs_o !== exp_o) begin
        bad++;
        $display("FAIL overflow_sb step=%0d got=%h want=%h", k, obs_o, exp_o);
      end
    end
    total++;
    if (count !== 3'd3 || full !== 1'b0 || fill_done !== 1'b1 || err !== 1'b1) begin
      bad++;
      $display("FAIL overflow_const count=%0d full=%b fd=%b err=%b", count, full, fill_done, err);
    end
  endtask

  task automatic test_underflow();
    // clr first so the error below is freshly raised by the underflow itself
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      exp_o = sb.pop_front();
      total++;
      if (k == 2) obs_o = sample();
      // only the final cycle's outputs are still visible; earlier entries checked by content
      if (k == 2 && obs_o !== exp_o) begin
        bad++;
        $display("FAIL underflow_sb got=%h want=%h", obs_o, exp_o);
      end else if (k == 1 && exp_o.err !== 1'b1) begin
        bad++;
        $display("FAIL underflow_model err=%b want=1", exp_o.err);
      end
    end
    total++;
    if (count !== 3'd0 || err !== 1'b1 || empty !== 1'b1) begin
      bad++;
      $display("FAIL underflow_const count=%0d err=%b empty=%b", count, err, empty);
    end
  endtask

  task automatic test_load();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    exp_o = sb.pop_front();
    obs_o = sample();
    total++;
    if (obs_o !== exp_o) begin
      bad++;
      $display("FAIL load7_sb got=%h want=%h", obs_o, exp_o);
    end
    total++;
    if (count !== 3'd4 || err !== 1'b1 || done_pulse !== 1'b1 || full !== 1'b1) begin
      bad++;
      $display("FAIL load7_const count=%0d err=%b dp=%b full=%b", count, err, done_pulse, full);
    end
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2);
    exp_o = sb.pop_front();
    obs_o = sample();
    total++;
    if (obs_o !== exp_o || count !== 3'd2 || done_pulse !== 1'b0) begin
      bad++;
      $display("FAIL load2_inc got=%h want=%h", obs_o, exp_o);
    end
  endtask

  task automatic test_clr();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    void'(sb.pop_front());
    total++;
    if (count !== 3'd3) begin
      bad++;
      $display("FAIL clr_setup count=%0d want=3", count);
    end
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    exp_o = sb.pop_front();
    obs_o = sample();
    total++;
    if (obs_o !== exp_o || obs_o !== obs_t'({3'd0, 1'b1, 5'b0})) begin
      bad++;
      $display("FAIL clr_with_inc got=%h want=%h", obs_o, exp_o);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    void'(sb.pop_front());
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    exp_o = sb.pop_front();
    obs_o = sample();
    total++;
    if (obs_o !== exp_o || obs_o !== obs_t'({3'd0, 1'b1, 5'b0})) begin
      bad++;
      $display("FAIL rst_with_load got=%h want=%h", obs_o, exp_o);
    end
  endtask

  task automatic test_back_to_back();
    logic r, c, i, d, l;
    logic [W-1:0] v;
    for (int k = 0; k < 200; k++) begin
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 19) == 0);
      i = $urandom_range(0, 1);
      d = $urandom_range(0, 1);
      l = ($urandom_range(0, 7) == 0);
      v = W'($urandom_range(0, 7));
      apply(r, c, i, d, l, v);
      exp_o = sb.pop_front();
      obs_o = sample();
      total++;
      if (obs_o !== exp_o) begin
        bad++;
        $display("FAIL random step=%0d got=%h want=%h", k, obs_o, exp_o);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_load();
    test_clr();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
